// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first: synchronizes rx, samples each bit at its centre, strobes irq per byte.
// Latency: irq rises 9.5*CLKS_PER_BIT + SYNC_STAGES cycles after the start-bit falling edge on rx.
// Backpressure: none; a frame completing while the previous byte is still pending sets sticky overrun.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_finish,
    output logic [7:0] rx_data,
    output logic       irq,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_WRAP = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   irq_q, irq_d;
    logic                   busy_q, busy_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   pend_q, pend_d;
    logic                   rxs;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign rxs    = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        irq_d     = 1'b0;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        pend_d    = pend_q;

        // A frame completing in the same cycle overrides the consume below.
        if (rx_finish) begin
            pend_d = 1'b0;
            ovr_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CNT_MID) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        ferr_d    = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CNT_WRAP) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rxs;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CNT_WRAP) begin
                    clk_cnt_d = '0;
                    rx_data_d = shift_q;
                    ferr_d    = ~rxs;
                    irq_d     = 1'b1;
                    ovr_d     = ovr_q | (pend_q & ~rx_finish);
                    pend_d    = 1'b1;
                    state_d   = rxs ? ST_IDLE : ST_BREAK;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy covers the frame itself plus the irq cycle.
        busy_d = (state_d == ST_START) || (state_d == ST_DATA) ||
                 (state_d == ST_STOP) || irq_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '1;
            clk_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            rx_data_q <= 8'd0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            irq_q     <= irq_d;
            busy_q    <= busy_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            pend_q    <= pend_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign irq       = irq_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame table, random frames against a pending/overrun model,
// plus hand sequences for glitch rejection and reset mid-frame.
module tb_uart_rx_core;

    localparam int CPB  = 16;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_finish = 1'b0;
    logic [7:0] rx_data;
    logic       irq;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_finish (rx_finish),
        .rx_data   (rx_data),
        .irq       (irq),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dat;
        logic       ferr;
        logic       busy;
        logic       ovr;
        int         cyc;
    } irq_rec_t;

    irq_rec_t mon_q[$];
    int       irq_total = 0;
    int       irq_wide  = 0;
    logic     irq_prev  = 1'b0;

    always @(negedge clk) begin
        if (irq === 1'b1) begin
            mon_q.push_back('{rx_data, frame_err, rx_busy, overrun, cyc});
            irq_total++;
            if (irq_prev === 1'b1) irq_wide++;
        end
        irq_prev = irq;
    end

    typedef struct {
        logic [7:0] dat;
        bit         stop_ok;
        int         fin_mode;  // 0 none, 1 pulse after irq, 2 pulse in the completion cycle
        int         gap;
        logic [7:0] exp_dat;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs[9];

    int n_vec    = 0;
    int n_err    = 0;
    int n_frames = 0;
    int last_start = 0;

    // Consumer-side model: one pending slot, sticky overrun.
    bit mdl_pend = 1'b0;
    bit mdl_ovr  = 1'b0;

    function automatic bit mdl_frame(input bit fin_same);
        if (mdl_pend && !fin_same) mdl_ovr = 1'b1;
        mdl_pend = 1'b1;
        return mdl_ovr;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge with the line idle-high.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit fin_same);
        rx = 1'b0;
        last_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        chk("busy_in_frame", 32'(rx_busy), 32'd1);
        chk("ferr_cleared_by_start", 32'(frame_err), 32'd0);
        rx = stop_ok;
        for (int k = 0; k < CPB; k++) begin
            rx_finish = fin_same && (cyc == last_start + 19 * CPB / 2 + SYNC);
            @(negedge clk);
        end
        rx_finish = 1'b0;
        if (!stop_ok) begin
            repeat (CPB) @(negedge clk);
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit stop_ok,
                             input int fin_mode, input int gap, input logic [7:0] exp_dat,
                             input bit exp_ferr, input bit exp_ovr);
        irq_rec_t m;
        int lat2;
        n_frames++;
        send_frame(b, stop_ok, fin_mode == 2);
        chk({tag, " irq_count"}, 32'(mon_q.size()), 32'd1);
        if (mon_q.size() > 0) begin
            m = mon_q[0];
            chk({tag, " rx_data"}, 32'(m.dat), 32'(exp_dat));
            chk({tag, " frame_err"}, 32'(m.ferr), 32'(exp_ferr));
            chk({tag, " busy_at_irq"}, 32'(m.busy), 32'd1);
            chk({tag, " overrun"}, 32'(m.ovr), 32'(exp_ovr));
            // Half-cycle units: rx falls mid-cycle, the irq flop rises on a posedge.
            lat2 = 2 * (m.cyc - last_start) - 1;
            n_vec++;
            if (lat2 < 19 * CPB + 2 * SYNC || lat2 > 19 * CPB + 2 * SYNC + 4) begin
                n_err++;
                $display("FAIL %s latency: got %0d half-cycles, expected %0d..%0d", tag,
                         lat2, 19 * CPB + 2 * SYNC, 19 * CPB + 2 * SYNC + 4);
            end
        end
        mon_q.delete();
        if (fin_mode == 1) begin
            rx_finish = 1'b1;
            @(negedge clk);
            rx_finish = 1'b0;
            mdl_pend = 1'b0;
            mdl_ovr  = 1'b0;
            @(negedge clk);
            chk({tag, " overrun_after_finish"}, 32'(overrun), 32'(mdl_ovr));
            chk({tag, " ferr_holds"}, 32'(frame_err), 32'(exp_ferr));
        end
        repeat (gap * CPB) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         s_ok;
        int         fm;
        int         gp;
        bit         e_ovr;

        vecs[0] = '{8'hA5, 1'b1, 1, 1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1, 1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1, 1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 0, 0, 8'h11, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 1, 1, 8'h22, 1'b0, 1'b1};
        vecs[5] = '{8'h33, 1'b1, 0, 1, 8'h33, 1'b0, 1'b0};
        vecs[6] = '{8'h44, 1'b1, 2, 1, 8'h44, 1'b0, 1'b0};
        vecs[7] = '{8'h55, 1'b1, 0, 1, 8'h55, 1'b0, 1'b1};
        vecs[8] = '{8'h66, 1'b1, 1, 1, 8'h66, 1'b0, 1'b1};

        #1 rst = 1'b1;
        #1;
        chk("reset_outputs", 32'({irq, rx_busy, rx_data, frame_err, overrun}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("idle_busy", 32'(rx_busy), 32'd0);

        for (int v = 0; v < 9; v++) begin
            void'(mdl_frame(vecs[v].fin_mode == 2));
            run_frame($sformatf("vec%0d", v), vecs[v].dat, vecs[v].stop_ok, vecs[v].fin_mode,
                      vecs[v].gap, vecs[v].exp_dat, vecs[v].exp_ferr, vecs[v].exp_ovr);
        end

        // Short low glitch on an idle line.
        rx = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_high", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        chk("glitch_busy_low", 32'(rx_busy), 32'd0);
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_no_irq", 32'(mon_q.size()), 32'd0);
        mon_q.delete();

        for (int r = 0; r < 14; r++) begin
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 3) != 0);
            fm   = int'($urandom_range(0, 2));
            gp   = s_ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            e_ovr = mdl_frame(fm == 2);
            run_frame($sformatf("rnd%0d", r), b, s_ok, fm, gp, b, !s_ok, e_ovr);
        end

        e_ovr = mdl_frame(1'b0);
        run_frame("pre_rst", 8'hC3, 1'b1, 0, 1, 8'hC3, 1'b0, e_ovr);

        // Reset in the middle of data bit 4 of 0xFF.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        chk("busy_before_rst", 32'(rx_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", 32'({irq, rx_busy, rx_data, frame_err, overrun}), 32'd0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mdl_pend = 1'b0;
        mdl_ovr  = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("rst_no_irq", 32'(mon_q.size()), 32'd0);
        mon_q.delete();

        e_ovr = mdl_frame(1'b0);
        run_frame("post_rst", 8'h5A, 1'b1, 1, 1, 8'h5A, 1'b0, e_ovr);

        chk("irq_single_cycle", 32'(irq_wide), 32'd0);
        chk("irq_total", 32'(irq_total), 32'(n_frames));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
